regbank_port_arbiter: RTL

Sequencer and two-requester arbiter in front of the 16 x 32-bit register bank. Owns the bank's write port, read port pair and reset line: runs the bank initialisation after system reset, then shares the single write port and the single dual-read port between requesters A and B with round-robin fairness. It also forwards same-cycle write data to reads so requesters never observe stale values.

---
 rtl/regbank_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/regbank_port_arbiter.sv
// regbank_port_arbiter: init sequencer plus round-robin write/read port arbiter
// for a 16 x 32-bit register bank. Reads go through a two-stage pipeline
// (bank command, result capture) with write-to-read forwarding.
module regbank_port_arbiter #(
    parameter int unsigned INIT_CYCLES = 1
) (
    input  logic        Clock_in,
    input  logic        Signal_reset,
    input  logic        Wr_req_a,
    input  logic        Wr_req_b,
    input  logic [3:0]  Wr_addr_a,
    input  logic [3:0]  Wr_addr_b,
    input  logic [31:0] Wr_data_a,
    input  logic [31:0] Wr_data_b,
    output logic        Wr_gnt_a,
    output logic        Wr_gnt_b,
    input  logic        Rd_req_a,
    input  logic        Rd_req_b,
    input  logic [3:0]  Rd_addr1_a,
    input  logic [3:0]  Rd_addr2_a,
    input  logic [3:0]  Rd_addr1_b,
    input  logic [3:0]  Rd_addr2_b,
    output logic        Rd_gnt_a,
    output logic        Rd_gnt_b,
    output logic        Rd_valid,
    output logic        Rd_owner,
    output logic [31:0] Rd_data1,
    output logic [31:0] Rd_data2,
    output logic        Bank_signal_reset,
    output logic        Bank_signal_write,
    output logic        Bank_signal_read,
    output logic [3:0]  Bank_address_to_write,
    output logic [3:0]  Bank_read_1,
    output logic [3:0]  Bank_read_2,
    output logic [31:0] Bank_data_to_write,
    input  logic [31:0] Bank_out_1,
    input  logic [31:0] Bank_out_2,
    output logic        Init_done
);

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_init_cnt;
    logic        r_bank_reset;
    logic        r_init_done;

    // Round-robin pointers: 0 = A has priority on a tie, 1 = B.
    logic        r_wr_ptr;
    logic        r_rd_ptr;

    // Bank command stage.
    logic        r_bank_write;
    logic [3:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_bank_read;
    logic [3:0]  r_rd_addr_1;
    logic [3:0]  r_rd_addr_2;
    logic        r_rd_owner_pend;

    // Result capture stage.
    logic        r_rd_valid;
    logic        r_rd_owner;
    logic [31:0] r_rd_data_1;
    logic [31:0] r_rd_data_2;

    logic        w_run;
    logic        w_bypass_1;
    logic        w_bypass_2;

    assign w_run = (r_state == ST_RUN);

    // Grants are purely combinational so a requester learns of its grant in the
    // same cycle it asserts the request; the pointer only breaks ties.
    assign Wr_gnt_a = w_run & Wr_req_a & (~Wr_req_b | ~r_wr_ptr);
    assign Wr_gnt_b = w_run & Wr_req_b & (~Wr_req_a |  r_wr_ptr);
    assign Rd_gnt_a = w_run & Rd_req_a & (~Rd_req_b | ~r_rd_ptr);
    assign Rd_gnt_b = w_run & Rd_req_b & (~Rd_req_a |  r_rd_ptr);

    // The bank commits the write at the end of the command cycle, so a read
    // command in that same cycle would see the old value without forwarding.
    assign w_bypass_1 = r_bank_write && (r_wr_addr == r_rd_addr_1);
    assign w_bypass_2 = r_bank_write && (r_wr_addr == r_rd_addr_2);

    // Sequencer FSM: RST -> INIT (bank reset held) -> RUN.
    always_ff @(posedge Clock_in) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and every
        // sequential assignment is non-blocking so all registers update from
        // pre-edge values regardless of statement order.
        if (!Signal_reset) begin
            r_state      <= ST_RST;
            r_init_cnt   <= '0;
            r_bank_reset <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state      <= ST_INIT;
                    r_init_cnt   <= 4'(INIT_CYCLES - 1);
                    r_bank_reset <= 1'b1;
                end
                ST_INIT: begin
                    if (r_init_cnt == '0) begin
                        r_state      <= ST_RUN;
                        r_bank_reset <= 1'b0;
                        r_init_done  <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Pointer update: after any grant the other side gets tie priority.
    always_ff @(posedge Clock_in) begin
        if (!Signal_reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (Wr_gnt_a)      r_wr_ptr <= 1'b1;
            else if (Wr_gnt_b) r_wr_ptr <= 1'b0;
            if (Rd_gnt_a)      r_rd_ptr <= 1'b1;
            else if (Rd_gnt_b) r_rd_ptr <= 1'b0;
        end
    end

    // Register the granted write/read into a one-cycle bank command.
    always_ff @(posedge Clock_in) begin
        if (!Signal_reset) begin
            r_bank_write    <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_bank_read     <= 1'b0;
            r_rd_addr_1     <= '0;
            r_rd_addr_2     <= '0;
            r_rd_owner_pend <= 1'b0;
        end else begin
            r_bank_write <= Wr_gnt_a | Wr_gnt_b;
            if (Wr_gnt_a) begin
                r_wr_addr <= Wr_addr_a;
                r_wr_data <= Wr_data_a;
            end else if (Wr_gnt_b) begin
                r_wr_addr <= Wr_addr_b;
                r_wr_data <= Wr_data_b;
            end
            r_bank_read <= Rd_gnt_a | Rd_gnt_b;
            if (Rd_gnt_a) begin
                r_rd_addr_1     <= Rd_addr1_a;
                r_rd_addr_2     <= Rd_addr2_a;
                r_rd_owner_pend <= 1'b0;
            end else if (Rd_gnt_b) begin
                r_rd_addr_1     <= Rd_addr1_b;
                r_rd_addr_2     <= Rd_addr2_b;
                r_rd_owner_pend <= 1'b1;
            end
        end
    end

    // Capture bank read data (or forwarded write data) at the end of the command cycle.
    always_ff @(posedge Clock_in) begin
        if (!Signal_reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_owner  <= 1'b0;
            r_rd_data_1 <= '0;
            r_rd_data_2 <= '0;
        end else begin
            r_rd_valid <= r_bank_read;
            if (r_bank_read) begin
                r_rd_owner  <= r_rd_owner_pend;
                r_rd_data_1 <= w_bypass_1 ? r_wr_data : Bank_out_1;
                r_rd_data_2 <= w_bypass_2 ? r_wr_data : Bank_out_2;
            end
        end
    end

    assign Bank_signal_reset     = r_bank_reset;
    assign Init_done             = r_init_done;
    assign Bank_signal_write     = r_bank_write;
    assign Bank_address_to_write = r_wr_addr;
    assign Bank_data_to_write    = r_wr_data;
    assign Bank_signal_read      = r_bank_read;
    assign Bank_read_1           = r_rd_addr_1;
    assign Bank_read_2           = r_rd_addr_2;
    assign Rd_valid              = r_rd_valid;
    assign Rd_owner              = r_rd_owner;
    assign Rd_data1              = r_rd_data_1;
    assign Rd_data2              = r_rd_data_2;

endmodule
